// File: rtl/gf163_inverter_if.sv
// gf163_inverter_if: operand/result handshake plus the operand/product path
// to the external karatsuba163 multiplier.
//   master : the surrounding datapath (issues start/a_in, returns mul_c)
//   slave  : the inverter
interface gf163_inverter_if;
   logic         start;
   logic [162:0] a_in;
   logic         busy;
   logic         done;
   logic [162:0] inv_out;
   logic [162:0] mul_a;
   logic [162:0] mul_b;
   logic [162:0] mul_c;

   modport master (
      output start, a_in, mul_c,
      input  busy, done, inv_out, mul_a, mul_b
   );

   modport slave (
      input  start, a_in, mul_c,
      output busy, done, inv_out, mul_a, mul_b
   );
endinterface

// File: rtl/gf163_inverter.sv
// gf163_inverter: Itoh-Tsujii inversion in GF(2^163), f = x^163+x^7+x^6+x^3+1.
// Addition chain 1-2-4-5-10-20-40-80-81-162 followed by one final squaring.
// Multiplications use the external karatsuba163 through mul_a/mul_b/mul_c;
// squarings are done locally.
// Build option: define GF163_QUAD_SQR_EN to square twice per cycle
// (latency 94 instead of 172, identical results).
//
// state | meaning
// IDLE  | waiting for start; inv_out holds the last result
// SQR   | acc <- acc^2 (or acc^4) until the step's squaring count is used up
// MUL   | acc <- acc * operand via the external multiplier, advance step
// FIN   | inv_out <- acc^2, done pulses in the following cycle
module gf163_inverter (
   input  logic            clk,
   input  logic            rst,
   gf163_inverter_if.slave bus
);

   typedef enum logic [1:0] {ST_IDLE, ST_SQR, ST_MUL, ST_FIN} state_t;

   state_t       state_q, state_d;
   logic [162:0] acc_q, acc_d;
   logic [162:0] base_q, base_d;
   logic [162:0] beta1_q, beta1_d;
   logic [162:0] inv_q, inv_d;
   logic [3:0]   step_q, step_d;
   logic [6:0]   cnt_q, cnt_d;
   logic         done_q, done_d;
   logic [162:0] sq1;
   logic [162:0] op_b;
   logic [162:0] mul_a, mul_b;
`ifdef GF163_QUAD_SQR_EN
   logic [162:0] sq2;
`endif

   // Squaring is a bit spread (a_i -> x^2i) followed by folding every term
   // above x^162 back with x^163 = x^7+x^6+x^3+1, highest term first so any
   // fold that lands above x^162 is folded again later in the loop.
   function automatic logic [162:0] gf_sqr(input logic [162:0] a);
      logic [324:0] s;
      s = '0;
      for (int i = 0; i < 163; i++) s[2*i] = a[i];
      for (int i = 324; i >= 163; i--) begin
         if (s[i]) s[i-163 +: 8] = s[i-163 +: 8] ^ 8'hC9;
      end
      return s[162:0];
   endfunction

   // Number of squarings preceding the multiplication of each chain step.
   function automatic logic [6:0] k_of(input logic [3:0] s);
      case (s)
         4'd0:    k_of = 7'd1;
         4'd1:    k_of = 7'd2;
         4'd2:    k_of = 7'd1;
         4'd3:    k_of = 7'd5;
         4'd4:    k_of = 7'd10;
         4'd5:    k_of = 7'd20;
         4'd6:    k_of = 7'd40;
         4'd7:    k_of = 7'd1;
         4'd8:    k_of = 7'd81;
         default: k_of = 7'd1;
      endcase
   endfunction

   assign sq1 = gf_sqr(acc_q);
`ifdef GF163_QUAD_SQR_EN
   assign sq2 = gf_sqr(sq1);
`endif

   // Steps ending at beta_5 and beta_81 add one to the exponent, so they
   // multiply by beta_1 instead of the step's starting value.
   assign op_b = ((step_q == 4'd2) || (step_q == 4'd7)) ? beta1_q : base_q;

   // Next-state, datapath updates and multiplier operands.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      base_d  = base_q;
      beta1_d = beta1_q;
      inv_d   = inv_q;
      step_d  = step_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      mul_a   = '0;
      mul_b   = '0;
      unique case (state_q)
         ST_IDLE: begin
            // done_q high means FIN was just left; a start in that cycle is not taken.
            if (bus.start && !done_q) begin
               acc_d   = bus.a_in;
               base_d  = bus.a_in;
               beta1_d = bus.a_in;
               step_d  = 4'd0;
               cnt_d   = k_of(4'd0);
               state_d = ST_SQR;
            end
         end
         ST_SQR: begin
`ifdef GF163_QUAD_SQR_EN
            if (cnt_q >= 7'd2) begin
               acc_d = sq2;
               cnt_d = cnt_q - 7'd2;
            end else begin
               acc_d = sq1;
               cnt_d = cnt_q - 7'd1;
            end
            if (cnt_q <= 7'd2) state_d = ST_MUL;
`else
            acc_d = sq1;
            cnt_d = cnt_q - 7'd1;
            if (cnt_q == 7'd1) state_d = ST_MUL;
`endif
         end
         ST_MUL: begin
            mul_a  = acc_q;
            mul_b  = op_b;
            acc_d  = bus.mul_c;
            base_d = bus.mul_c;
            step_d = step_q + 4'd1;
            if (step_q == 4'd8) begin
               state_d = ST_FIN;
            end else begin
               cnt_d   = k_of(step_q + 4'd1);
               state_d = ST_SQR;
            end
         end
         ST_FIN: begin
            inv_d   = sq1;
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         acc_q   <= '0;
         base_q  <= '0;
         beta1_q <= '0;
         inv_q   <= '0;
         step_q  <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         base_q  <= base_d;
         beta1_q <= beta1_d;
         inv_q   <= inv_d;
         step_q  <= step_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   assign bus.busy    = (state_q != ST_IDLE);
   assign bus.done    = done_q;
   assign bus.inv_out = inv_q;
   assign bus.mul_a   = mul_a;
   assign bus.mul_b   = mul_b;

endmodule

// File: tb/tb_gf163_inverter.sv
// tb_gf163_inverter: directed and random checks of gf163_inverter against a
// shift-and-add GF(2^163) multiplier model that also stands in for karatsuba163.
// Cycle numbering: the cycle in which start is presented is cycle 0.
module tb_gf163_inverter;
`ifdef GF163_QUAD_SQR_EN
   localparam int LAT = 94;
`else
   localparam int LAT = 172;
`endif
   localparam logic [162:0] ONE = 163'd1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   gf163_inverter_if bus ();
   gf163_inverter dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   // Field product: schoolbook shift-and-add, reducing each x*t step by f.
   function automatic logic [162:0] gf_mul(input logic [162:0] a, input logic [162:0] b);
      logic [162:0] r;
      logic [162:0] t;
      r = '0;
      t = a;
      for (int i = 0; i < 163; i++) begin
         if (b[i]) r = r ^ t;
         t = t[162] ? ({t[161:0], 1'b0} ^ 163'hC9) : {t[161:0], 1'b0};
      end
      return r;
   endfunction

   assign bus.mul_c = gf_mul(bus.mul_a, bus.mul_b);

   function automatic logic [162:0] rand163();
      logic [162:0] r;
      for (int i = 0; i < 163; i++) r[i] = 1'($urandom_range(0, 1));
      return r;
   endfunction

   function automatic logic [162:0] rand_nz();
      logic [162:0] r;
      r = rand163();
      while (r == '0) r = rand163();
      return r;
   endfunction

   task automatic chk(input string tag, input logic [162:0] obs, input logic [162:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_bit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Called #1 into cycle first_cyc; watches through cycle LAT+4, optionally
   // re-pulsing start with a2 during cycle repulse_at.
   task automatic wait_done(input int first_cyc, input int repulse_at, input logic [162:0] a2,
                            output int lat, output int ndone, output logic [162:0] res);
      lat   = -1;
      ndone = 0;
      res   = '0;
      for (int cyc = first_cyc; cyc <= LAT + 4; cyc++) begin
         if (bus.done === 1'b1) begin
            ndone++;
            if (lat < 0) begin
               lat = cyc;
               res = bus.inv_out;
            end
         end
         if (cyc == repulse_at) begin
            bus.start = 1'b1;
            bus.a_in  = a2;
         end else begin
            bus.start = 1'b0;
         end
         @(posedge clk);
         #1;
      end
      bus.start = 1'b0;
   endtask

   // Presents a in cycle 0, scrambles a_in afterwards, checks the first
   // multiplication's operands (a^2 times a) and waits for the result.
   task automatic run_op(input logic [162:0] a, input int repulse_at, input logic [162:0] a2,
                         output int lat, output int ndone, output logic [162:0] res);
      bus.a_in  = a;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.a_in  = rand163();
      chk_bit("busy_cycle1", bus.busy, 1'b1);
      chk("mul_a_idle_in_sqr", bus.mul_a, '0);
      @(posedge clk);
      #1;
      chk("mul_a_first_mul", bus.mul_a, gf_mul(a, a));
      chk("mul_b_first_mul", bus.mul_b, a);
      wait_done(2, repulse_at, a2, lat, ndone, res);
   endtask

   initial begin
      logic [162:0] a;
      logic [162:0] b;
      logic [162:0] res;
      logic [162:0] xinv;
      int           lat;
      int           nd;

      bus.start = 1'b0;
      bus.a_in  = '0;
      xinv      = (ONE << 162) | 163'h64;

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_bit("rst_busy", bus.busy, 1'b0);
      chk_bit("rst_done", bus.done, 1'b0);
      chk("rst_inv_out", bus.inv_out, '0);
      chk("rst_mul_a", bus.mul_a, '0);
      chk("rst_mul_b", bus.mul_b, '0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      run_op(ONE, -1, '0, lat, nd, res);
      chk_int("lat_one", lat, LAT);
      chk_int("ndone_one", nd, 1);
      chk("inv_one", res, ONE);
      chk("inv_hold_one", bus.inv_out, ONE);
      chk_bit("busy_after_one", bus.busy, 1'b0);

      run_op(163'd2, -1, '0, lat, nd, res);
      chk_int("lat_x", lat, LAT);
      chk("inv_x", res, xinv);

      run_op('0, -1, '0, lat, nd, res);
      chk_int("lat_zero", lat, LAT);
      chk("inv_zero", res, '0);

      a = '1;
      run_op(a, -1, '0, lat, nd, res);
      chk_int("lat_ones", lat, LAT);
      chk("prod_ones", gf_mul(a, res), ONE);

      for (int n = 0; n < 50; n++) begin
         a = rand_nz();
         run_op(a, -1, '0, lat, nd, res);
         chk_int("lat_rand", lat, LAT);
         chk("prod_rand", gf_mul(a, res), ONE);
      end

      // Second start while busy must be ignored.
      a = rand_nz();
      b = rand_nz();
      while (b == a) b = rand_nz();
      run_op(a, 10, b, lat, nd, res);
      chk_int("lat_repulse", lat, LAT);
      chk_int("ndone_repulse", nd, 1);
      chk("prod_repulse", gf_mul(a, res), ONE);

      // Start held from the done cycle: taken one cycle later.
      a = rand_nz();
      b = rand_nz();
      bus.a_in  = a;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      lat = -1;
      res = '0;
      for (int cyc = 1; cyc <= LAT + 4; cyc++) begin
         if (bus.done === 1'b1) begin
            lat = cyc;
            res = bus.inv_out;
            break;
         end
         @(posedge clk);
         #1;
      end
      chk_int("lat_b2b_first", lat, LAT);
      chk("prod_b2b_first", gf_mul(a, res), ONE);
      bus.start = 1'b1;
      bus.a_in  = b;
      @(posedge clk);
      #1;
      chk_bit("b2b_not_taken_in_done", bus.busy, 1'b0);
      chk_bit("b2b_done_single", bus.done, 1'b0);
      @(posedge clk);
      #1;
      chk_bit("b2b_taken_next", bus.busy, 1'b1);
      bus.start = 1'b0;
      bus.a_in  = rand163();
      wait_done(1, -1, '0, lat, nd, res);
      chk_int("lat_b2b_second", lat, LAT);
      chk_int("ndone_b2b_second", nd, 1);
      chk("prod_b2b_second", gf_mul(b, res), ONE);

      // Reset during cycle 50 of an inversion.
      a = rand_nz();
      bus.a_in  = a;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (49) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk_bit("midrst_busy", bus.busy, 1'b0);
      chk_bit("midrst_done", bus.done, 1'b0);
      chk("midrst_inv_out", bus.inv_out, '0);
      chk("midrst_mul_a", bus.mul_a, '0);
      wait_done(1, -1, '0, lat, nd, res);
      chk_int("midrst_no_done", nd, 0);

      a = rand_nz();
      run_op(a, -1, '0, lat, nd, res);
      chk_int("lat_after_rst", lat, LAT);
      chk("prod_after_rst", gf_mul(a, res), ONE);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
